// File: rtl/id_scanner_if.sv
// Character-stream interface for id_scanner: the character source drives the
// char/valid/flush inputs, and the scanner returns its token reports.
interface id_scanner_if #(
  parameter int LEN_W = 5,
  parameter int CNT_W = 8
);
  logic [7:0]       char;
  logic             char_valid;
  logic             flush;
  logic             out;
  logic [LEN_W-1:0] id_len;
  logic             err;
  logic [CNT_W-1:0] id_count;
  logic             busy;

  modport master (
    output char, char_valid, flush,
    input  out, id_len, err, id_count, busy
  );

  modport slave (
    input  char, char_valid, flush,
    output out, id_len, err, id_count, busy
  );
endinterface

// File: rtl/id_scanner.sv
// Streaming ASCII identifier recognizer: one character per valid cycle, reports
// each terminated identifier (with length) or flags malformed/overlong tokens.
module id_scanner #(
  parameter int MAX_LEN          = 16,
  parameter int LEN_W            = 5,
  parameter int CNT_W            = 8,
  parameter int ALLOW_UNDERSCORE = 1
) (
  input  logic         clk,
  input  logic         reset,
  id_scanner_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IDENT = 2'd1,
    BAD   = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_uscore(input logic [7:0] c);
    return (ALLOW_UNDERSCORE != 0) && (c == 8'h5F);
  endfunction

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             out_q, out_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] id_len_q, id_len_d;
  logic [CNT_W-1:0] id_count_q, id_count_d;
  logic             busy_q, busy_d;

  logic ch_start, ch_digit, ch_word;
  logic term_ok, term_bad;

  assign ch_start = is_letter(bus.char) || is_uscore(bus.char);
  assign ch_digit = is_digit(bus.char);
  assign ch_word  = ch_start || ch_digit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      out_q      <= 1'b0;
      err_q      <= 1'b0;
      id_len_q   <= '0;
      id_count_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      out_q      <= out_d;
      err_q      <= err_d;
      id_len_q   <= id_len_d;
      id_count_q <= id_count_d;
      busy_q     <= busy_d;
    end
  end

  // flush overrides the character: it behaves as a delimiter and char is ignored.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    term_ok  = 1'b0;
    term_bad = 1'b0;
    if (bus.flush) begin
      case (state_q)
        IDENT: begin
          state_d = IDLE;
          len_d   = '0;
          term_ok = 1'b1;
        end
        BAD: begin
          state_d  = IDLE;
          len_d    = '0;
          term_bad = 1'b1;
        end
        default: ;
      endcase
    end else if (bus.char_valid) begin
      case (state_q)
        IDLE: begin
          if (ch_start) begin
            state_d = IDENT;
            len_d   = LEN_W'(1);
          end else if (ch_digit) begin
            state_d = BAD;
          end
        end
        IDENT: begin
          if (ch_word) begin
            if (len_q == LEN_MAX) begin
              state_d = BAD;
            end else begin
              len_d = len_q + LEN_W'(1);
            end
          end else begin
            state_d = IDLE;
            len_d   = '0;
            term_ok = 1'b1;
          end
        end
        BAD: begin
          if (!ch_word) begin
            state_d  = IDLE;
            len_d    = '0;
            term_bad = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          len_d   = '0;
        end
      endcase
    end
  end

  // Report registers: len_q still holds the finished token's length on termination.
  always_comb begin
    out_d      = term_ok;
    err_d      = term_bad;
    id_len_d   = term_ok ? len_q : id_len_q;
    id_count_d = term_ok ? (id_count_q + CNT_W'(1)) : id_count_q;
    busy_d     = (state_d != IDLE);
  end

  assign bus.out      = out_q;
  assign bus.err      = err_q;
  assign bus.id_len   = id_len_q;
  assign bus.id_count = id_count_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_id_scanner.sv
// Directed bench for id_scanner: four parameter variants share one stimulus
// stream; each scenario task checks the variant it targets.
module tb_id_scanner;

  logic       clk = 1'b0;
  logic       reset_s = 1'b0;
  logic [7:0] char_s = 8'h00;
  logic       valid_s = 1'b0;
  logic       flush_s = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  // a: defaults, b: MAX_LEN=4, c: no underscore, d: CNT_W=2
  id_scanner_if #(.LEN_W(5), .CNT_W(8)) ifa ();
  id_scanner_if #(.LEN_W(3), .CNT_W(8)) ifb ();
  id_scanner_if #(.LEN_W(5), .CNT_W(8)) ifc ();
  id_scanner_if #(.LEN_W(5), .CNT_W(2)) ifd ();

  assign ifa.char = char_s;  assign ifa.char_valid = valid_s;  assign ifa.flush = flush_s;
  assign ifb.char = char_s;  assign ifb.char_valid = valid_s;  assign ifb.flush = flush_s;
  assign ifc.char = char_s;  assign ifc.char_valid = valid_s;  assign ifc.flush = flush_s;
  assign ifd.char = char_s;  assign ifd.char_valid = valid_s;  assign ifd.flush = flush_s;

  id_scanner #(.MAX_LEN(16), .LEN_W(5), .CNT_W(8), .ALLOW_UNDERSCORE(1))
    dut_a (.clk(clk), .reset(reset_s), .bus(ifa));
  id_scanner #(.MAX_LEN(4), .LEN_W(3), .CNT_W(8), .ALLOW_UNDERSCORE(1))
    dut_b (.clk(clk), .reset(reset_s), .bus(ifb));
  id_scanner #(.MAX_LEN(16), .LEN_W(5), .CNT_W(8), .ALLOW_UNDERSCORE(0))
    dut_c (.clk(clk), .reset(reset_s), .bus(ifc));
  id_scanner #(.MAX_LEN(16), .LEN_W(5), .CNT_W(2), .ALLOW_UNDERSCORE(1))
    dut_d (.clk(clk), .reset(reset_s), .bus(ifd));

  task automatic send(input logic [7:0] c);
    char_s = c; valid_s = 1'b1; flush_s = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle_cycle();
    char_s = 8'h00; valid_s = 1'b0; flush_s = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_flush(input logic [7:0] c);
    char_s = c; valid_s = 1'b1; flush_s = 1'b1;
    @(posedge clk); #1;
    flush_s = 1'b0; valid_s = 1'b0;
  endtask

  task automatic do_reset();
    reset_s = 1'b0; valid_s = 1'b0; flush_s = 1'b0;
    @(posedge clk); #1;
    reset_s = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (ifa.out !== 1'b0) begin n_miss++; $display("FAIL reset_out: got %b want 0", ifa.out); end
    n_vec++; if (ifa.err !== 1'b0) begin n_miss++; $display("FAIL reset_err: got %b want 0", ifa.err); end
    n_vec++; if (ifa.id_len !== 5'd0) begin n_miss++; $display("FAIL reset_id_len: got %0d want 0", ifa.id_len); end
    n_vec++; if (ifa.id_count !== 8'd0) begin n_miss++; $display("FAIL reset_id_count: got %0d want 0", ifa.id_count); end
    n_vec++; if (ifa.busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", ifa.busy); end
    n_vec++; if (ifd.id_count !== 2'd0) begin n_miss++; $display("FAIL reset_id_count_d: got %0d want 0", ifd.id_count); end
  endtask

  task automatic test_basic();
    send(8'h61);
    n_vec++; if (ifa.busy !== 1'b1) begin n_miss++; $display("FAIL basic_busy_first: got %b want 1", ifa.busy); end
    send_str("b1");
    n_vec++; if (ifa.out !== 1'b0) begin n_miss++; $display("FAIL basic_out_early: got %b want 0", ifa.out); end
    send(8'h20);
    n_vec++; if (ifa.out !== 1'b1) begin n_miss++; $display("FAIL basic_out: got %b want 1", ifa.out); end
    n_vec++; if (ifa.id_len !== 5'd3) begin n_miss++; $display("FAIL basic_id_len: got %0d want 3", ifa.id_len); end
    n_vec++; if (ifa.id_count !== 8'd1) begin n_miss++; $display("FAIL basic_id_count: got %0d want 1", ifa.id_count); end
    n_vec++; if (ifa.err !== 1'b0) begin n_miss++; $display("FAIL basic_err: got %b want 0", ifa.err); end
    n_vec++; if (ifa.busy !== 1'b0) begin n_miss++; $display("FAIL basic_busy_end: got %b want 0", ifa.busy); end
    idle_cycle();
    n_vec++; if (ifa.out !== 1'b0) begin n_miss++; $display("FAIL basic_out_pulse: got %b want 0", ifa.out); end
    n_vec++; if (ifa.id_len !== 5'd3) begin n_miss++; $display("FAIL basic_id_len_hold: got %0d want 3", ifa.id_len); end
  endtask

  task automatic test_bad_start();
    send_str("9x");
    n_vec++; if (ifa.busy !== 1'b1) begin n_miss++; $display("FAIL badstart_busy: got %b want 1", ifa.busy); end
    send(8'h20);
    n_vec++; if (ifa.err !== 1'b1) begin n_miss++; $display("FAIL badstart_err: got %b want 1", ifa.err); end
    n_vec++; if (ifa.out !== 1'b0) begin n_miss++; $display("FAIL badstart_out: got %b want 0", ifa.out); end
    n_vec++; if (ifa.id_count !== 8'd1) begin n_miss++; $display("FAIL badstart_id_count: got %0d want 1", ifa.id_count); end
    idle_cycle();
    n_vec++; if (ifa.err !== 1'b0) begin n_miss++; $display("FAIL badstart_err_pulse: got %b want 0", ifa.err); end
  endtask

  task automatic test_overflow();
    string s = "abcde;";
    do_reset();
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      n_vec++; if (ifb.out !== 1'b0) begin n_miss++; $display("FAIL ovf_no_out[%0d]: got %b want 0", i, ifb.out); end
    end
    n_vec++; if (ifb.err !== 1'b1) begin n_miss++; $display("FAIL ovf_err: got %b want 1", ifb.err); end
    send_str("abcd");
    n_vec++; if (ifb.busy !== 1'b1) begin n_miss++; $display("FAIL ovf_busy_at_max: got %b want 1", ifb.busy); end
    send(8'h3B);
    n_vec++; if (ifb.out !== 1'b1) begin n_miss++; $display("FAIL maxlen_out: got %b want 1", ifb.out); end
    n_vec++; if (ifb.id_len !== 3'd4) begin n_miss++; $display("FAIL maxlen_id_len: got %0d want 4", ifb.id_len); end
    n_vec++; if (ifb.id_count !== 8'd1) begin n_miss++; $display("FAIL maxlen_id_count: got %0d want 1", ifb.id_count); end
    n_vec++; if (ifb.err !== 1'b0) begin n_miss++; $display("FAIL maxlen_err: got %b want 0", ifb.err); end
  endtask

  task automatic test_underscore();
    do_reset();
    send(8'h5F);
    n_vec++; if (ifa.busy !== 1'b1) begin n_miss++; $display("FAIL us_busy_allow: got %b want 1", ifa.busy); end
    n_vec++; if (ifc.busy !== 1'b0) begin n_miss++; $display("FAIL us_busy_deny: got %b want 0", ifc.busy); end
    send_str("a1 ");
    n_vec++; if (ifa.out !== 1'b1) begin n_miss++; $display("FAIL us_allow_out: got %b want 1", ifa.out); end
    n_vec++; if (ifa.id_len !== 5'd3) begin n_miss++; $display("FAIL us_allow_id_len: got %0d want 3", ifa.id_len); end
    n_vec++; if (ifc.out !== 1'b1) begin n_miss++; $display("FAIL us_deny_out: got %b want 1", ifc.out); end
    n_vec++; if (ifc.id_len !== 5'd2) begin n_miss++; $display("FAIL us_deny_id_len: got %0d want 2", ifc.id_len); end
    n_vec++; if (ifc.id_count !== 8'd1) begin n_miss++; $display("FAIL us_deny_id_count: got %0d want 1", ifc.id_count); end
  endtask

  task automatic test_gaps_flush();
    do_reset();
    send(8'h61);
    for (int i = 0; i < 5; i++) begin
      idle_cycle();
      n_vec++; if (ifa.busy !== 1'b1 || ifa.out !== 1'b0)
        begin n_miss++; $display("FAIL gap_hold[%0d]: got busy=%b out=%b want busy=1 out=0", i, ifa.busy, ifa.out); end
    end
    send(8'h62);
    do_flush(8'h63);
    n_vec++; if (ifa.out !== 1'b1) begin n_miss++; $display("FAIL flush_out: got %b want 1", ifa.out); end
    n_vec++; if (ifa.id_len !== 5'd2) begin n_miss++; $display("FAIL flush_id_len: got %0d want 2", ifa.id_len); end
    n_vec++; if (ifa.busy !== 1'b0) begin n_miss++; $display("FAIL flush_busy: got %b want 0", ifa.busy); end
    idle_cycle();
    n_vec++; if (ifa.out !== 1'b0) begin n_miss++; $display("FAIL flush_out_pulse: got %b want 0", ifa.out); end
    do_flush(8'h61);
    n_vec++; if (ifa.out !== 1'b0 || ifa.err !== 1'b0 || ifa.busy !== 1'b0)
      begin n_miss++; $display("FAIL flush_idle: got out=%b err=%b busy=%b want 0 0 0", ifa.out, ifa.err, ifa.busy); end
    send(8'h39);
    do_flush(8'h20);
    n_vec++; if (ifa.err !== 1'b1 || ifa.out !== 1'b0)
      begin n_miss++; $display("FAIL flush_bad: got err=%b out=%b want err=1 out=0", ifa.err, ifa.out); end
    n_vec++; if (ifa.id_count !== 8'd1) begin n_miss++; $display("FAIL flush_id_count: got %0d want 1", ifa.id_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_str("x;");
    n_vec++; if (ifa.out !== 1'b1 || ifa.id_len !== 5'd1)
      begin n_miss++; $display("FAIL b2b_first: got out=%b len=%0d want out=1 len=1", ifa.out, ifa.id_len); end
    send(8'h79);
    n_vec++; if (ifa.out !== 1'b0 || ifa.busy !== 1'b1)
      begin n_miss++; $display("FAIL b2b_restart: got out=%b busy=%b want out=0 busy=1", ifa.out, ifa.busy); end
    send_str("z;");
    n_vec++; if (ifa.out !== 1'b1 || ifa.id_len !== 5'd2)
      begin n_miss++; $display("FAIL b2b_second: got out=%b len=%0d want out=1 len=2", ifa.out, ifa.id_len); end
    n_vec++; if (ifa.id_count !== 8'd2) begin n_miss++; $display("FAIL b2b_id_count: got %0d want 2", ifa.id_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_str("ab");
    do_reset();
    n_vec++; if (ifa.out !== 1'b0 || ifa.busy !== 1'b0)
      begin n_miss++; $display("FAIL midreset_state: got out=%b busy=%b want 0 0", ifa.out, ifa.busy); end
    n_vec++; if (ifa.id_count !== 8'd0) begin n_miss++; $display("FAIL midreset_id_count: got %0d want 0", ifa.id_count); end
    idle_cycle();
    n_vec++; if (ifa.out !== 1'b0 || ifa.err !== 1'b0)
      begin n_miss++; $display("FAIL midreset_no_pulse: got out=%b err=%b want 0 0", ifa.out, ifa.err); end
  endtask

  task automatic test_count_wrap();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_str("a;");
      n_vec++; if (ifd.id_count !== exp_cnt[i])
        begin n_miss++; $display("FAIL wrap_id_count[%0d]: got %0d want %0d", i, ifd.id_count, exp_cnt[i]); end
    end
  endtask

  initial begin
    reset_s = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_bad_start();
    test_overflow();
    test_underscore();
    test_gaps_flush();
    test_back_to_back();
    test_reset_mid();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/id_scanner.md
Name: id_scanner

Overview:
- Streaming ASCII identifier recognizer: consumes one character per valid cycle and detects tokens of the form letter (or '_') followed by letters/digits/'_'.
- Parametrised successor of the single-char identifier FSM. Adds:
  - input valid qualifier
  - synchronous reset
  - maximum-length check
  - underscore mode
  - token length report
  - error pulse for malformed tokens
  - running identifier count
- Sits between a character source (UART RX / ROM reader) and downstream lexer/counter logic.

Parameters:
- MAX_LEN, 16, longest accepted identifier in characters (1..2^LEN_W-1).
- LEN_W, 5, width of id_len; must hold MAX_LEN.
- CNT_W, 8, width of id_count; wraps modulo 2^CNT_W.
- ALLOW_UNDERSCORE, 1:
  - 1: '_' (8'h5F) is a word character.
  - 0: '_' is a delimiter.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-low reset; sampled on clk rising edge.
- char, input, 8, ASCII character.
- char_valid, input, 1, char is consumed this cycle when 1.
- flush, input, 1, end-of-stream; terminates the current token as if a delimiter arrived.
- out, output, 1, one-cycle pulse: a valid identifier just terminated.
- id_len, output, LEN_W, length of the identifier reported by out; holds its value between pulses.
- err, output, 1, one-cycle pulse: a malformed or overlong token just terminated.
- id_count, output, CNT_W, number of valid identifiers since reset.
- busy, output, 1, state != IDLE.

Behaviour:

Character classes:
- letter: 8'h41-8'h5A, 8'h61-8'h7A.
- digit: 8'h30-8'h39.
- word: letter, digit, or '_' (the latter only if ALLOW_UNDERSCORE).
- delimiter: everything else, including NUL.

Reset (reset==0 at a rising edge):
- state=IDLE, internal len=0.
- out=0, err=0, id_len=0, id_count=0, busy=0.
- Reset mid-token discards the token with no pulse.

States:
- IDLE: between tokens.
- IDENT: inside a valid identifier.
- BAD: inside a token that began with a digit or exceeded MAX_LEN.

Transitions (evaluated only when char_valid=1 and flush=0):
- IDLE:
  - letter or allowed '_' -> IDENT, len=1.
  - digit -> BAD.
  - delimiter -> IDLE.
- IDENT:
  - word char with len<MAX_LEN -> IDENT, len=len+1.
  - word char with len==MAX_LEN -> BAD (overflow).
  - delimiter -> IDLE; next cycle out=1, id_len=len, id_count=id_count+1.
- BAD:
  - word char -> BAD.
  - delimiter -> IDLE; next cycle err=1.

flush:
- flush=1 applies the delimiter action of the current state.
- char is ignored that cycle, even if char_valid=1.
- flush in IDLE has no effect.

Other rules:
- char_valid=0 and flush=0: state and len hold; out and err return to 0.
- Latency: out/err assert exactly one cycle after the terminating delimiter/flush is sampled and stay high for one cycle only.
- Back-to-back: the delimiter that ends one token may be followed next cycle by the start of a new token with no gap.
- out and err are never both 1.
- id_count wraps from 2^CNT_W-1 to 0 without flag.
- id_len is registered together with out; it holds its last value otherwise.
- busy is registered from the next-state value, so busy=1 the cycle after the first word char is accepted.

Test Plan:
- Reset then stream "ab1 " (8'h61,8'h62,8'h31,8'h20) with char_valid=1 -> out=1 for one cycle after the space, id_len=3, id_count=1, err=0.
- Stream "9x " -> no out; err pulses once after the space; id_count unchanged.
- MAX_LEN=4: stream "abcde;" -> BAD after 'e', err pulse after ';', out never asserts. Stream "abcd;" -> out with id_len=4.
- Underscore mode:
  - ALLOW_UNDERSCORE=1: "_a1 " -> out, id_len=3.
  - ALLOW_UNDERSCORE=0: same stream -> '_' acts as delimiter, then "a1" reported with id_len=2.
- Gaps and flush: "a", char_valid=0 for 5 cycles, "b", then flush=1 with char_valid=1 char="c" -> out, id_len=2, 'c' ignored, busy=0 afterwards.
- Reset mid-token: "ab" then reset=0 for one cycle -> no out, id_count=0. Then CNT_W=2 with 5 identifiers "a;" x5 -> id_count sequence 1,2,3,0,1.
